// File: rtl/tcs_serial_cmp_if.sv
// rtl/tcs_serial_cmp_if.sv - request/result bundle for the digit-serial magnitude comparator
interface tcs_serial_cmp_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             eq_in;
    logic             gt_in;
    logic             busy;
    logic             done;
    logic             eq_out;
    logic             gt_out;

    modport master (
        output start, a, b, eq_in, gt_in,
        input  busy, done, eq_out, gt_out
    );

    modport slave (
        input  start, a, b, eq_in, gt_in,
        output busy, done, eq_out, gt_out
    );
endinterface

// File: rtl/tcs_serial_cmp.sv
// rtl/tcs_serial_cmp.sv - cascadable digit-serial comparator, MSB slice first; TCS_SIGNED_CMP_EN selects two's complement operands
module tcs_serial_cmp #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 2
) (
    input  logic             clk,
    input  logic             reset,
    tcs_serial_cmp_if.slave  cmp
);
    localparam int NUM_DIGITS = WIDTH / DIGIT;
    localparam int IDX_W      = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);

    typedef enum logic {
        IDLE,
        CMP
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               done_q, done_d;
    logic               eq_q, eq_d;
    logic               gt_q, gt_d;
    logic [DIGIT-1:0]   a_sl, b_sl;

    // Operands shift left as slices match, so the slice under test is always the top one.
    always_comb begin
        a_sl = a_q[WIDTH-1 -: DIGIT];
        b_sl = b_q[WIDTH-1 -: DIGIT];
`ifdef TCS_SIGNED_CMP_EN
        if (idx_q == LAST_IDX) begin
            a_sl[DIGIT-1] = ~a_sl[DIGIT-1];
            b_sl[DIGIT-1] = ~b_sl[DIGIT-1];
        end
`else
`endif
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        idx_d   = idx_q;
        done_d  = 1'b0;
        eq_d    = eq_q;
        gt_d    = gt_q;
        case (state_q)
            IDLE: begin
                if (cmp.start) begin
                    a_d = cmp.a;
                    b_d = cmp.b;
                    if (cmp.eq_in) begin
                        idx_d   = LAST_IDX;
                        state_d = CMP;
                    end else begin
                        eq_d   = 1'b0;
                        gt_d   = cmp.gt_in;
                        done_d = 1'b1;
                    end
                end
            end
            CMP: begin
                if (a_sl > b_sl) begin
                    eq_d    = 1'b0;
                    gt_d    = 1'b1;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else if (a_sl < b_sl) begin
                    eq_d    = 1'b0;
                    gt_d    = 1'b0;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else if (idx_q != '0) begin
                    idx_d = idx_q - IDX_W'(1);
                    a_d   = a_q << DIGIT;
                    b_d   = b_q << DIGIT;
                end else begin
                    eq_d    = 1'b1;
                    gt_d    = 1'b0;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            idx_q   <= '0;
            done_q  <= 1'b0;
            eq_q    <= 1'b0;
            gt_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            idx_q   <= idx_d;
            done_q  <= done_d;
            eq_q    <= eq_d;
            gt_q    <= gt_d;
        end
    end

    assign cmp.busy   = (state_q == CMP);
    assign cmp.done   = done_q;
    assign cmp.eq_out = eq_q;
    assign cmp.gt_out = gt_q;
endmodule

// File: tb/tb_tcs_serial_cmp.sv
// tb/tb_tcs_serial_cmp.sv - scoreboard bench for tcs_serial_cmp with randomized and directed compares
module tb_tcs_serial_cmp;
    localparam int W = 8;
    localparam int D = 2;
    localparam int N = W / D;

    typedef struct {
        logic eq;
        logic gt;
        int   cyc;
    } exp_t;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    int   cyc   = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];
    exp_t m_e;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    tcs_serial_cmp_if #(.WIDTH(W)) bus ();

    tcs_serial_cmp #(.WIDTH(W), .DIGIT(D)) dut (
        .clk   (clk),
        .reset (reset),
        .cmp   (bus)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Position (1 = most significant) of the first differing slice, or N when all match.
    function automatic int ref_lat(input logic [W-1:0] x, input logic [W-1:0] y);
        int xi = int'(x);
        int yi = int'(y);
        for (int k = 1; k <= N; k++) begin
            int sh = (N - k) * D;
            if (((xi >> sh) % (1 << D)) != ((yi >> sh) % (1 << D))) return k;
        end
        return N;
    endfunction

    task automatic issue(input logic [W-1:0] x, input logic [W-1:0] y, input logic ei, input logic gi);
        exp_t e;
        int   acc = cyc + 1;
        bus.a     = x;
        bus.b     = y;
        bus.eq_in = ei;
        bus.gt_in = gi;
        bus.start = 1'b1;
        if (!ei) begin
            e.eq  = 1'b0;
            e.gt  = gi;
            e.cyc = acc;
        end else begin
            e.eq = (x == y);
`ifdef TCS_SIGNED_CMP_EN
            e.gt = ($signed(x) > $signed(y));
`else
            e.gt = (x > y);
`endif
            e.cyc = acc + ref_lat(x, y);
        end
        sb.push_back(e);
    endtask

    task automatic scramble_inputs();
        bus.a     = W'($urandom);
        bus.b     = W'($urandom);
        bus.eq_in = 1'($urandom);
        bus.gt_in = 1'($urandom);
    endtask

    // Issue at a negedge, then count cycles busy stays high after acceptance.
    task automatic directed(input string name, input logic [W-1:0] x, input logic [W-1:0] y,
                            input logic ei, input logic gi, input int exp_busy);
        int bc = 0;
        issue(x, y, ei, gi);
        @(negedge clk);
        bus.start = 1'b0;
        scramble_inputs();
        while (bus.busy && bc < 40) begin
            bc++;
            @(negedge clk);
        end
        check(name, bc, exp_busy);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 40; i++) begin
            if (!bus.busy) return;
            @(negedge clk);
        end
        check("wait_idle_timeout", 32'd1, 32'd0);
    endtask

    always @(negedge clk) begin
        if (reset === 1'b1 && bus.done === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got done=1 expected no pending compare (t=%0t)", $time);
            end else begin
                m_e = sb.pop_front();
                check("eq_out", bus.eq_out, m_e.eq);
                check("gt_out", bus.gt_out, m_e.gt);
                check("done_cycle", cyc, m_e.cyc);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] x, y;
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        bus.eq_in = 1'b0;
        bus.gt_in = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        check("rst_eq", bus.eq_out, 0);
        check("rst_gt", bus.gt_out, 0);
        reset = 1'b1;
        @(negedge clk);

        directed("busy_equal", 8'hA5, 8'hA5, 1'b1, 1'b0, 4);
        directed("busy_msb", 8'h80, 8'h7F, 1'b1, 1'b0, 1);
        directed("busy_lsb", 8'h34, 8'h36, 1'b1, 1'b0, 4);
        directed("busy_bypass", 8'h00, 8'hFF, 1'b0, 1'b1, 0);
        @(negedge clk);
`ifdef TCS_SIGNED_CMP_EN
        directed("busy_signed_lsb", 8'hFF, 8'hFE, 1'b1, 1'b0, 4);
`else
`endif

        // Start pulse while busy must not disturb the compare in flight.
        issue(8'h34, 8'h36, 1'b1, 1'b0);
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        bus.a = 8'hFF; bus.b = 8'h00; bus.eq_in = 1'b1; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        wait_idle();
        @(negedge clk);

        // Asynchronous reset mid-compare aborts it with no done.
        directed("busy_pre_abort", 8'h40, 8'h3F, 1'b1, 1'b0, 1);
        issue(8'hA5, 8'hA5, 1'b1, 1'b0);
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        check("abort_busy_before", bus.busy, 1);
        #2 reset = 1'b0;
        #1;
        check("abort_busy", bus.busy, 0);
        check("abort_done", bus.done, 0);
        check("abort_eq", bus.eq_out, 0);
        check("abort_gt", bus.gt_out, 0);
        sb.delete();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        repeat (8) @(negedge clk);
        check("abort_idle", bus.busy, 0);

        for (int it = 0; it < 400; it++) begin
            @(negedge clk);
            bus.start = 1'b0;
            if (!bus.busy && $urandom_range(0, 2) != 0) begin
                x = W'($urandom);
                case ($urandom_range(0, 2))
                    0:       y = W'($urandom);
                    1:       y = x;
                    default: y = x ^ (W'(1) << $urandom_range(0, W - 1));
                endcase
                issue(x, y, ($urandom_range(0, 7) != 0), 1'($urandom));
            end else if (bus.busy && $urandom_range(0, 3) == 0) begin
                scramble_inputs();
                bus.start = 1'b1;
            end
        end
        @(negedge clk);
        bus.start = 1'b0;
        wait_idle();
        repeat (3) @(negedge clk);
        check("scoreboard_drained", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
